fetch_pipeline_unit: RTL and testbench

FETCH_PIPELINE_UNIT -- requirements
Module: fetch_pipeline_unit

---
 rtl/fetch_pipeline_unit_pkg.sv | 20 ++
 rtl/fetch_pipeline_unit_pc_npc_register.sv | 53 +++++
 rtl/fetch_pipeline_unit.sv | 99 +++++++++
 tb/tb_fetch_pipeline_unit.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/fetch_pipeline_unit_pkg.sv
// Shared fetch-pipeline definitions: reset/bubble constants, IF/ID record, address alignment.
package fetch_pipeline_unit_pkg;

   localparam logic [31:0] RESET_PC   = 32'h0000_0000;
   localparam logic [31:0] NOP_WORD   = 32'h0000_0000;
   localparam logic [31:0] WORD_BYTES = 32'd4;

   // Contents of the IF/ID pipeline register
   typedef struct packed {
      logic [31:0] instruction;
      logic [31:0] pc;
      logic        valid;
   } if_id_t;

   // Instruction fetches are word aligned; the low byte-offset bits are dropped
   function automatic logic [31:0] align_word(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_pipeline_unit_pc_npc_register.sv
// PC/NPC pair: PC is the address being fetched, NPC the address fetched after it.
// A redirect replaces NPC, so the word at PC (the delay slot) is always fetched.
module pc_npc_register #(
   parameter logic [31:0] RESET_PC = fetch_pipeline_unit_pkg::RESET_PC
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        pc_enable,
   input  logic        imem_ready,
   input  logic        redirect,
   input  logic [31:0] branch_target,
   output logic [31:0] pc,
   output logic [31:0] npc
);
   import fetch_pipeline_unit_pkg::*;

   logic [31:0] pc_reg;
   logic [31:0] npc_reg;
   logic [31:0] pc_next;
   logic [31:0] npc_next;
   logic [31:0] target_aligned;

   assign target_aligned = align_word(branch_target);

   // Next-state: advance on completed fetch, otherwise hold PC but still capture a redirect
   always_comb begin
      pc_next  = pc_reg;
      npc_next = npc_reg;
      if (pc_enable) begin
         if (imem_ready) begin
            pc_next  = npc_reg;
            npc_next = redirect ? target_aligned : (npc_reg + WORD_BYTES);
         end else if (redirect) begin
            npc_next = target_aligned;
         end
      end
   end

   // PC/NPC state; reset discards any pending redirect
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_reg  <= RESET_PC;
         npc_reg <= RESET_PC + WORD_BYTES;
      end else begin
         pc_reg  <= pc_next;
         npc_reg <= npc_next;
      end
   end

   assign pc  = pc_reg;
   assign npc = npc_reg;

endmodule

// File: rtl/fetch_pipeline_unit.sv
// Instruction fetch stage: PC/NPC sequencing, IF/ID register and imem wait-cycle counter.
module fetch_pipeline_unit #(
   parameter logic [31:0] RESET_PC = fetch_pipeline_unit_pkg::RESET_PC,
   parameter logic [31:0] NOP_WORD = fetch_pipeline_unit_pkg::NOP_WORD
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        pc_enable,
   input  logic        load_enable,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_data,
   input  logic        imem_ready,
   output logic [31:0] id_instruction,
   output logic [31:0] id_pc,
   output logic        id_valid,
   output logic [15:0] fetch_stall_count
);
   import fetch_pipeline_unit_pkg::*;

   logic        redirect;
   logic [31:0] pc;
   logic [31:0] npc;
   if_id_t      if_id_reg;
   if_id_t      if_id_next;
   logic [15:0] stall_count_reg;
   logic [15:0] stall_count_next;

   // A branch only redirects when ID holds a real instruction and the pipe is not stalled
   assign redirect = pc_enable & if_id_reg.valid & branch_taken;

   pc_npc_register #(
      .RESET_PC (RESET_PC)
   ) u_pc_npc (
      .clk           (clk),
      .reset         (reset),
      .pc_enable     (pc_enable),
      .imem_ready    (imem_ready),
      .redirect      (redirect),
      .branch_target (branch_target),
      .pc            (pc),
      .npc           (npc)
   );

   assign imem_addr = pc;

   // IF/ID load: real word on completed fetch, bubble while imem is still busy
   always_comb begin
      if_id_next = if_id_reg;
      if (pc_enable && load_enable) begin
         if (imem_ready) begin
            if_id_next.instruction = imem_data;
            if_id_next.pc          = pc;
            if_id_next.valid       = 1'b1;
         end else begin
            if_id_next.instruction = NOP_WORD;
            if_id_next.pc          = pc;
            if_id_next.valid       = 1'b0;
         end
      end
   end

   // IF/ID register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         if_id_reg.instruction <= NOP_WORD;
         if_id_reg.pc          <= 32'h0;
         if_id_reg.valid       <= 1'b0;
      end else begin
         if_id_reg <= if_id_next;
      end
   end

   // Stall counter: counts cycles the fetch stage waits on imem, saturating at all-ones
   always_comb begin
      stall_count_next = stall_count_reg;
      if (pc_enable && !imem_ready && (stall_count_reg != 16'hFFFF))
         stall_count_next = stall_count_reg + 16'd1;
   end

   // Stall counter register
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         stall_count_reg <= 16'h0;
      else
         stall_count_reg <= stall_count_next;
   end

   assign id_instruction    = if_id_reg.instruction;
   assign id_pc             = if_id_reg.pc;
   assign id_valid          = if_id_reg.valid;
   assign fetch_stall_count = stall_count_reg;

   // npc is internal to the sequencer; it is observed here only to keep every net used
   logic unused_npc;
   assign unused_npc = ^npc;

endmodule

// File: tb/tb_fetch_pipeline_unit.sv
// Directed bench for fetch_pipeline_unit: sequencing, delay slot, stalls, waits, wrap, reset.
module tb_fetch_pipeline_unit;

   localparam logic [31:0] KEY = 32'hC0DE_0000;

   logic        clk;
   logic        reset;
   logic        pc_enable;
   logic        load_enable;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic [31:0] imem_addr;
   logic [31:0] imem_data;
   logic        imem_ready;
   logic [31:0] id_instruction;
   logic [31:0] id_pc;
   logic        id_valid;
   logic [15:0] fetch_stall_count;

   int checks;
   int errors;
   int step_no;

   fetch_pipeline_unit dut (
      .clk               (clk),
      .reset             (reset),
      .pc_enable         (pc_enable),
      .load_enable       (load_enable),
      .branch_taken      (branch_taken),
      .branch_target     (branch_target),
      .imem_addr         (imem_addr),
      .imem_data         (imem_data),
      .imem_ready        (imem_ready),
      .id_instruction    (id_instruction),
      .id_pc             (id_pc),
      .id_valid          (id_valid),
      .fetch_stall_count (fetch_stall_count)
   );

   // Memory model: every word is tagged with its own address
   assign imem_data = imem_addr ^ KEY;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      step_no++;
      $display("step %0d addr=%h id_pc=%h id_instr=%h valid=%0b stalls=%0d",
               step_no, imem_addr, id_pc, id_instruction, id_valid, fetch_stall_count);
   endtask

   initial begin
      checks        = 0;
      errors        = 0;
      step_no       = 0;
      reset         = 1'b1;
      pc_enable     = 1'b1;
      load_enable   = 1'b1;
      branch_taken  = 1'b0;
      branch_target = 32'h0;
      imem_ready    = 1'b1;

      // Reset state
      #2;
      chk("rst_addr",   imem_addr, 32'h0);
      chk("rst_instr",  id_instruction, 32'h0);
      chk("rst_idpc",   id_pc, 32'h0);
      chk("rst_valid",  {31'h0, id_valid}, 32'h0);
      chk("rst_count",  {16'h0, fetch_stall_count}, 32'h0);
      @(posedge clk);
      #2;
      reset = 1'b0;

      // Sequential fetch 0,4,8
      chk("seq_addr0", imem_addr, 32'h0);
      step();
      chk("seq_addr4", imem_addr, 32'h4);
      chk("seq_idpc0", id_pc, 32'h0);
      chk("seq_valid", {31'h0, id_valid}, 32'h1);
      chk("seq_instr0", id_instruction, 32'h0 ^ KEY);
      step();
      chk("seq_addr8", imem_addr, 32'h8);
      chk("seq_idpc4", id_pc, 32'h4);

      // Taken branch while fetching 8: order 8, C (delay slot), 100, 104
      branch_taken  = 1'b1;
      branch_target = 32'h100;
      step();
      chk("br_addrC", imem_addr, 32'hC);
      branch_taken = 1'b0;
      step();
      chk("br_addr100", imem_addr, 32'h100);
      chk("br_idpcC", id_pc, 32'hC);
      step();
      chk("br_addr104", imem_addr, 32'h104);
      chk("br_instr100", id_instruction, 32'h100 ^ KEY);

      // Load-use stall with branch pending: everything holds, redirect on release
      pc_enable     = 1'b0;
      load_enable   = 1'b0;
      branch_taken  = 1'b1;
      branch_target = 32'h200;
      for (int i = 0; i < 2; i++) begin
         step();
         chk("hold_addr",  imem_addr, 32'h104);
         chk("hold_idpc",  id_pc, 32'h100);
         chk("hold_instr", id_instruction, 32'h100 ^ KEY);
         chk("hold_count", {16'h0, fetch_stall_count}, 32'h0);
      end
      pc_enable   = 1'b1;
      load_enable = 1'b1;
      step();
      chk("rel_addr108", imem_addr, 32'h108);
      chk("rel_idpc104", id_pc, 32'h104);
      branch_taken = 1'b0;
      step();
      chk("rel_addr200", imem_addr, 32'h200);

      // imem wait for 3 cycles with branch taken in the first
      imem_ready    = 1'b0;
      branch_taken  = 1'b1;
      branch_target = 32'h300;
      step();
      chk("wait_addr",   imem_addr, 32'h200);
      chk("wait_valid",  {31'h0, id_valid}, 32'h0);
      chk("wait_idpc",   id_pc, 32'h200);
      chk("wait_instr",  id_instruction, 32'h0);
      chk("wait_count1", {16'h0, fetch_stall_count}, 32'h1);
      branch_taken = 1'b0;
      step();
      step();
      chk("wait_valid3", {31'h0, id_valid}, 32'h0);
      chk("wait_count3", {16'h0, fetch_stall_count}, 32'h3);
      imem_ready = 1'b1;
      step();
      chk("wait_slot_idpc", id_pc, 32'h200);
      chk("wait_slot_valid", {31'h0, id_valid}, 32'h1);
      chk("wait_addr300", imem_addr, 32'h300);
      step();
      chk("wait_tgt_idpc", id_pc, 32'h300);
      chk("wait_count_hold", {16'h0, fetch_stall_count}, 32'h3);

      // Misaligned target is aligned; PC wraps from FFFFFFFC to 0
      branch_taken  = 1'b1;
      branch_target = 32'hFFFF_FFFE;
      step();
      branch_taken = 1'b0;
      step();
      chk("wrap_addr_top", imem_addr, 32'hFFFF_FFFC);
      step();
      chk("wrap_addr0", imem_addr, 32'h0);
      chk("wrap_idpc", id_pc, 32'hFFFF_FFFC);
      step();
      chk("wrap_addr4", imem_addr, 32'h4);

      // Redirect captured during a wait, then reset drops it
      imem_ready    = 1'b0;
      branch_taken  = 1'b1;
      branch_target = 32'h500;
      step();
      chk("mid_addr", imem_addr, 32'h4);
      chk("mid_count", {16'h0, fetch_stall_count}, 32'h4);
      #2;
      reset = 1'b1;
      #1;
      chk("async_addr",  imem_addr, 32'h0);
      chk("async_valid", {31'h0, id_valid}, 32'h0);
      chk("async_count", {16'h0, fetch_stall_count}, 32'h0);
      #2;
      reset        = 1'b0;
      branch_taken = 1'b0;
      imem_ready   = 1'b1;
      step();
      chk("post_rst_addr", imem_addr, 32'h4);
      chk("post_rst_idpc", id_pc, 32'h0);
      chk("post_rst_valid", {31'h0, id_valid}, 32'h1);

      // load_enable low: PC advances, IF/ID holds
      load_enable = 1'b0;
      step();
      chk("ld_hold_addr", imem_addr, 32'h8);
      chk("ld_hold_idpc", id_pc, 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
